// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 keyboard receiver. Synchronises the raw PS/2
// clock/data pins, frames 11-bit device-to-host packets (start, 8 data
// LSB first, odd parity, stop), and folds the E0 (extended) and F0
// (break) prefixes into a 16-bit key code plus a make/break level.
//
// Optional build macro: PS2_GLITCH_FILTER_EN
//   When defined, the synchronised PS/2 clock passes through an 8-sample
//   agreement filter before edge detection, so pulses shorter than 8 Clk
//   are ignored (edge latency grows by 8 Clk).
module ps2_scancode_rx #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        psClk,
  input  logic        psData,
  output logic [15:0] keyCode,
  output logic        press,
  output logic        code_valid,
  output logic        frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Synchroniser chains; the bus idles high so they reset to all ones.
  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   sync_clk;
  logic                   sync_data;
  logic                   edge_src;

  // Shift both pins through SYNC_STAGES flops to settle metastability.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_sync_reg  <= '1;
      data_sync_reg <= '1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], psClk};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], psData};
    end
  end

  assign sync_clk  = clk_sync_reg[SYNC_STAGES-1];
  assign sync_data = data_sync_reg[SYNC_STAGES-1];

`ifdef PS2_GLITCH_FILTER_EN
  logic       filt_clk_reg;
  logic [2:0] filt_cnt_reg;

  // Filtered clock follows the synchronised clock only after 8 agreeing samples.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      filt_clk_reg <= 1'b1;
      filt_cnt_reg <= 3'd0;
    end else if (sync_clk == filt_clk_reg) begin
      filt_cnt_reg <= 3'd0;
    end else if (filt_cnt_reg == 3'd7) begin
      filt_clk_reg <= sync_clk;
      filt_cnt_reg <= 3'd0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + 3'd1;
    end
  end

  assign edge_src = filt_clk_reg;
`else
  assign edge_src = sync_clk;
`endif

  logic clk_prev_reg;
  logic fe_reg;
  logic fe_data_reg;

  // Registered falling-edge strobe, with the data bit captured alongside it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_prev_reg <= 1'b1;
      fe_reg       <= 1'b0;
      fe_data_reg  <= 1'b1;
    end else begin
      clk_prev_reg <= edge_src;
      fe_reg       <= clk_prev_reg & ~edge_src;
      fe_data_reg  <= sync_data;
    end
  end

  state_t        state_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic          ext_reg;
  logic          brk_reg;
  logic [TW-1:0] tmo_cnt_reg;

  // Frame FSM, prefix folding, timeout and all registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= 3'd0;
      shift_reg   <= 8'h00;
      parity_reg  <= 1'b0;
      ext_reg     <= 1'b0;
      brk_reg     <= 1'b0;
      tmo_cnt_reg <= '0;
      keyCode     <= 16'h0000;
      press       <= 1'b0;
      code_valid  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fe_reg) begin
        // An edge always restarts the timeout, even if it was about to expire.
        tmo_cnt_reg <= '0;
        case (state_reg)
          IDLE: begin
            if (!fe_data_reg) begin
              state_reg   <= DATA;
              bit_cnt_reg <= 3'd0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shift_reg   <= {fe_data_reg, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= PARITY;
            end
          end
          PARITY: begin
            parity_reg <= fe_data_reg;
            state_reg  <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
            if (fe_data_reg && ((^shift_reg) ^ parity_reg)) begin
              if (shift_reg == 8'hE0) begin
                ext_reg <= 1'b1;
              end else if (shift_reg == 8'hF0) begin
                brk_reg <= 1'b1;
              end else begin
                keyCode    <= {(ext_reg ? 8'hE0 : 8'h00), shift_reg};
                press      <= ~brk_reg;
                code_valid <= 1'b1;
                ext_reg    <= 1'b0;
                brk_reg    <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              ext_reg   <= 1'b0;
              brk_reg   <= 1'b0;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end else if (state_reg != IDLE) begin
        if (tmo_cnt_reg == TMO_LAST) begin
          state_reg   <= IDLE;
          frame_err   <= 1'b1;
          ext_reg     <= 1'b0;
          brk_reg     <= 1'b0;
          tmo_cnt_reg <= '0;
        end else begin
          tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
      end else begin
        tmo_cnt_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: directed PS/2 frames with hand-computed expected codes.
module tb_ps2_scancode_rx;

  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        psClk = 1'b1;
  logic        psData = 1'b1;
  logic [15:0] keyCode;
  logic        press;
  logic        code_valid;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int cv0;
  int fe0;

  ps2_scancode_rx #(
    .TIMEOUT_CYCLES(TMO),
    .SYNC_STAGES   (2)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .psClk     (psClk),
    .psData    (psData),
    .keyCode   (keyCode),
    .press     (press),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  always #5 Clk = ~Clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge Clk) begin
    if (code_valid) cv_cnt <= cv_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (code_valid && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic bit_out(input logic b);
    psData = b;
    repeat (HALF) @(posedge Clk);
    psClk = 1'b0;
    repeat (HALF) @(posedge Clk);
    psClk = 1'b1;
  endtask

  // Full frame; par_ok=0 sends the wrong (even) parity bit.
  task automatic send_frame(input logic [7:0] b, input logic par_ok);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(par_ok ? ~(^b) : (^b));
    bit_out(1'b1);
    psData = 1'b1;
    repeat (HALF) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic snap();
    @(negedge Clk);
    cv0 = cv_cnt;
    fe0 = fe_cnt;
  endtask

  initial begin
    logic [7:0] part;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_keycode", 32'(keyCode), 32'h0000);
    check("rst_press", 32'(press), 32'h0);
    check("rst_code_valid", 32'(code_valid), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    Reset_n = 1'b1;
    repeat (5) @(posedge Clk);

    // Make code 1D
    snap();
    send_frame(8'h1D, 1'b1);
    check("make_keycode", 32'(keyCode), 32'h001D);
    check("make_press", 32'(press), 32'h1);
    check("make_cv_pulses", 32'(cv_cnt - cv0), 32'd1);
    check("make_err_pulses", 32'(fe_cnt - fe0), 32'd0);

    // Break: F0 then 1D
    snap();
    send_frame(8'hF0, 1'b1);
    check("brk_prefix_no_cv", 32'(cv_cnt - cv0), 32'd0);
    check("brk_prefix_hold", 32'(keyCode), 32'h001D);
    send_frame(8'h1D, 1'b1);
    check("brk_keycode", 32'(keyCode), 32'h001D);
    check("brk_press", 32'(press), 32'h0);
    check("brk_cv_pulses", 32'(cv_cnt - cv0), 32'd1);

    // Extended break E0 F0 75, then plain 29
    snap();
    send_frame(8'hE0, 1'b1);
    send_frame(8'hF0, 1'b1);
    send_frame(8'h75, 1'b1);
    check("ext_keycode", 32'(keyCode), 32'hE075);
    check("ext_press", 32'(press), 32'h0);
    check("ext_cv_pulses", 32'(cv_cnt - cv0), 32'd1);
    send_frame(8'h29, 1'b1);
    check("plain_keycode", 32'(keyCode), 32'h0029);
    check("plain_press", 32'(press), 32'h1);

    // Parity error on 1D, then good 1C
    snap();
    send_frame(8'h1D, 1'b0);
    check("par_err_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("par_no_cv", 32'(cv_cnt - cv0), 32'd0);
    check("par_keycode_hold", 32'(keyCode), 32'h0029);
    check("par_press_hold", 32'(press), 32'h1);
    send_frame(8'h1C, 1'b1);
    check("post_par_keycode", 32'(keyCode), 32'h001C);
    check("post_par_err_total", 32'(fe_cnt - fe0), 32'd1);

    // Timeout: start + 4 data bits of 29, then idle
    snap();
    part = 8'h29;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(part[i]);
    psData = 1'b1;
    repeat (TMO + 100) @(posedge Clk);
    @(negedge Clk);
    check("tmo_err_pulses", 32'(fe_cnt - fe0), 32'd1);
    check("tmo_no_cv", 32'(cv_cnt - cv0), 32'd0);
    send_frame(8'h29, 1'b1);
    check("post_tmo_keycode", 32'(keyCode), 32'h0029);
    check("post_tmo_cv", 32'(cv_cnt - cv0), 32'd1);

    // Reset after 5 data bits of an E0 prefix
    send_frame(8'hE0, 1'b1);
    part = 8'hE0;
    bit_out(1'b0);
    for (int i = 0; i < 5; i++) bit_out(part[i]);
    repeat (3) @(posedge Clk);
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    check("mid_rst_keycode", 32'(keyCode), 32'h0000);
    check("mid_rst_press", 32'(press), 32'h0);
    check("mid_rst_cv", 32'(code_valid), 32'h0);
    check("mid_rst_err", 32'(frame_err), 32'h0);
    psData = 1'b1;
    Reset_n = 1'b1;
    repeat (10) @(posedge Clk);
    snap();
    send_frame(8'h74, 1'b1);
    check("post_rst_keycode", 32'(keyCode), 32'h0074);
    check("post_rst_press", 32'(press), 32'h1);
    check("post_rst_err", 32'(fe_cnt - fe0), 32'd0);

`ifdef PS2_GLITCH_FILTER_EN
    // Short low glitch on the clock pin while idle
    snap();
    psClk = 1'b0;
    repeat (3) @(posedge Clk);
    psClk = 1'b1;
    repeat (30) @(posedge Clk);
    @(negedge Clk);
    check("glitch_no_err", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_no_cv", 32'(cv_cnt - cv0), 32'd0);
`endif

    @(negedge Clk);
    check("never_cv_and_err", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
